// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB occupancy to drive operand forwarding,
// load-use stalls, multi-cycle EX holds and branch flushes for a 5-stage pipeline.
module hazard_ctrl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [2:0] id_rs1,
   input  logic [2:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [2:0] id_rd,
   input  logic       id_reg_write,
   input  logic       id_mem_read,
   input  logic       id_multi,
   input  logic       branch_taken,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b,
   output logic       pc_write_en,
   output logic       ifid_write_en,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       idex_hold,
   output logic       exmem_bubble,
   output logic       ex_busy
);

   typedef enum logic [1:0] {RUN, LD_STALL, MUL_BUSY} state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       multi;
   } slot_t;

   localparam int EX  = 0;
   localparam int MEM = 1;
   localparam int WB  = 2;
   localparam logic [1:0] BUSY_INIT = 2'(MUL_CYCLES - 2);

   slot_t      slot [3];
   logic [2:0] ex_rs1, ex_rs2;
   logic       ex_use1, ex_use2;
   state_t     state, state_nx;
   logic [1:0] cnt, cnt_nx;
   logic       load_use;

   // Nearest producer wins: MEM is younger than WB, so it is checked first.
   function automatic logic [1:0] fwd_sel(input logic [2:0] src, input logic en,
                                          input slot_t mem, input slot_t wb);
      if (!en || src == 3'd0)                                  return 2'b00;
      else if (mem.valid && mem.reg_write && mem.rd == src)    return 2'b10;
      else if (wb.valid && wb.reg_write && wb.rd == src)       return 2'b01;
      else                                                     return 2'b00;
   endfunction

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      idex_hold     = 1'b0;
      exmem_bubble  = 1'b0;
      ex_busy       = 1'b0;
      forward_a     = 2'b00;
      forward_b     = 2'b00;
      load_use      = slot[EX].valid && slot[EX].mem_read && slot[EX].rd != 3'd0 && id_valid &&
                      ((id_use_rs1 && id_rs1 == slot[EX].rd) || (id_use_rs2 && id_rs2 == slot[EX].rd));
      if (!rst) begin
         forward_a = fwd_sel(ex_rs1, ex_use1, slot[MEM], slot[WB]);
         forward_b = fwd_sel(ex_rs2, ex_use2, slot[MEM], slot[WB]);
         case (state)
            RUN: begin
               if (slot[EX].valid && slot[EX].multi) begin
                  ex_busy       = 1'b1;
                  pc_write_en   = 1'b0;
                  ifid_write_en = 1'b0;
                  idex_hold     = 1'b1;
                  exmem_bubble  = 1'b1;
                  cnt_nx        = BUSY_INIT;
                  state_nx      = MUL_BUSY;
               end else if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (load_use) begin
                  pc_write_en   = 1'b0;
                  ifid_write_en = 1'b0;
                  idex_bubble   = 1'b1;
                  state_nx      = LD_STALL;
               end
            end
            LD_STALL: state_nx = RUN;
            MUL_BUSY: begin
               // Count of zero is the release cycle: op still in EX but advances at this edge.
               ex_busy = 1'b1;
               if (cnt == 2'd0) begin
                  state_nx = RUN;
               end else begin
                  pc_write_en   = 1'b0;
                  ifid_write_en = 1'b0;
                  idex_hold     = 1'b1;
                  exmem_bubble  = 1'b1;
                  cnt_nx        = cnt - 2'd1;
               end
            end
            default: state_nx = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
         for (int i = 0; i < 3; i++) slot[i] <= '0;
         ex_rs1  <= '0;
         ex_rs2  <= '0;
         ex_use1 <= 1'b0;
         ex_use2 <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         slot[WB] <= slot[MEM];
         if (exmem_bubble) slot[MEM] <= '0;
         else              slot[MEM] <= slot[EX];
         if (!idex_hold) begin
            if (idex_bubble) begin
               slot[EX] <= '0;
               ex_rs1   <= '0;
               ex_rs2   <= '0;
               ex_use1  <= 1'b0;
               ex_use2  <= 1'b0;
            end else begin
               slot[EX] <= '{id_valid, id_rd, id_reg_write, id_mem_read, id_multi};
               ex_rs1   <= id_rs1;
               ex_rs2   <= id_rs2;
               ex_use1  <= id_use_rs1;
               ex_use2  <= id_use_rs2;
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus random traffic for hazard_ctrl, checked every cycle against
// an instruction-level pipeline model kept in the bench.
module tb_hazard_ctrl;
   localparam int MC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_multi, branch_taken;
   logic [2:0] id_rs1, id_rs2, id_rd;
   logic [1:0] forward_a, forward_b;
   logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble, idex_hold, exmem_bubble, ex_busy;

   always #5 clk = ~clk;

   hazard_ctrl #(.MUL_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multi(id_multi),
      .branch_taken(branch_taken), .forward_a(forward_a), .forward_b(forward_b),
      .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_bubble(exmem_bubble),
      .ex_busy(ex_busy)
   );

   typedef struct {
      bit       v;
      bit [2:0] rd;
      bit       rw, mr, mu;
      bit [2:0] s1, s2;
      bit       u1, u2;
   } ins_t;

   // Model: the instruction occupying each stage, plus how long the EX one has sat there.
   ins_t m_ex, m_mem, m_wb, nop;
   int   m_age;
   int   compared = 0, mismatched = 0;
   int   last_fa, last_fb, last_pc, last_flush, last_bub, last_exb, last_busy;

   function automatic ins_t mk(bit v, bit [2:0] rd, bit rw, bit mr, bit mu,
                               bit [2:0] s1, bit u1, bit [2:0] s2, bit u2);
      ins_t i;
      i.v = v; i.rd = rd; i.rw = rw; i.mr = mr; i.mu = mu;
      i.s1 = s1; i.u1 = u1; i.s2 = s2; i.u2 = u2;
      return i;
   endfunction

   function automatic int fwd(bit [2:0] src, bit en);
      if (!en || src == 0) return 0;
      if (m_mem.v && m_mem.rw && m_mem.rd == src) return 2;
      if (m_wb.v && m_wb.rw && m_wb.rd == src) return 1;
      return 0;
   endfunction

   task automatic chk(string tag, int o, int e);
      compared++;
      assert (o === e) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic set_id(ins_t i, bit br);
      id_valid = i.v; id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr; id_multi = i.mu;
      id_rs1 = i.s1; id_use_rs1 = i.u1; id_rs2 = i.s2; id_use_rs2 = i.u2;
      branch_taken = br;
   endtask

   // Called just after a rising edge with inputs applied; checks at the falling edge.
   task automatic step(string tag);
      bit busy, hold, lu, br, bub, stall;
      int e, o;
      ins_t id_i;
      #4;
      busy  = m_ex.v && m_ex.mu;
      hold  = busy && (m_age < MC - 1);
      lu    = !busy && m_ex.v && m_ex.mr && m_ex.rd != 0 && id_valid &&
              ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
      br    = branch_taken && !busy;
      bub   = br || lu;
      stall = hold || (lu && !br);
      if (rst) e = 11'b00_00_1_1_0_0_0_0_0;
      else     e = {fwd(m_ex.s1, m_ex.u1) >= 2, fwd(m_ex.s1, m_ex.u1) % 2 == 1,
                    fwd(m_ex.s2, m_ex.u2) >= 2, fwd(m_ex.s2, m_ex.u2) % 2 == 1,
                    !stall, !stall, br, bub, hold, hold, busy};
      o = {21'b0, forward_a, forward_b, pc_write_en, ifid_write_en, ifid_flush,
           idex_bubble, idex_hold, exmem_bubble, ex_busy};
      last_fa = forward_a; last_fb = forward_b; last_pc = pc_write_en; last_flush = ifid_flush;
      last_bub = idex_bubble; last_exb = exmem_bubble; last_busy = ex_busy;
      chk(tag, o, e);
      id_i = mk(id_valid, id_rd, id_reg_write, id_mem_read, id_multi,
                id_rs1, id_use_rs1, id_rs2, id_use_rs2);
      @(posedge clk);
      #1;
      if (rst) begin
         m_ex = nop; m_mem = nop; m_wb = nop; m_age = 0;
      end else if (hold) begin
         m_wb = m_mem; m_mem = nop; m_age++;
      end else begin
         m_wb = m_mem; m_mem = m_ex; m_ex = bub ? nop : id_i; m_age = 0;
      end
   endtask

   task automatic drain();
      set_id(nop, 0);
      for (int i = 0; i < 3; i++) step("drain");
   endtask

   initial begin
      int nstall, nbusy, nexb, seen;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_ex = nop; m_mem = nop; m_wb = nop; m_age = 0;
      rst = 1'b1;
      set_id(mk(1, 1, 1, 0, 0, 1, 1, 1, 1), 1);
      @(posedge clk); #1;
      step("reset_a");
      step("reset_b");
      rst = 1'b0;
      set_id(nop, 0);
      step("post_reset");
      chk("post_reset_pc", last_pc, 1);

      // Back-to-back ALU: r1 producer then two readers.
      nstall = 0;
      set_id(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), 0); step("alu_p");   nstall += !last_pc;
      set_id(mk(1, 3, 1, 0, 0, 1, 1, 0, 0), 0); step("alu_c1");  nstall += !last_pc;
      set_id(mk(1, 4, 1, 0, 0, 1, 1, 0, 0), 0); step("alu_c2");  nstall += !last_pc;
      chk("alu_fa_mem", last_fa, 2);
      set_id(nop, 0);                           step("alu_nop"); nstall += !last_pc;
      chk("alu_fa_wb", last_fa, 1);
      chk("alu_no_stall", nstall, 0);
      drain();

      // Load r2 then consumer of r2 on rs2.
      nstall = 0;
      set_id(mk(1, 2, 1, 1, 0, 0, 0, 0, 0), 0); step("ld_p");  nstall += !last_pc;
      set_id(mk(1, 5, 1, 0, 0, 0, 0, 2, 1), 0); step("ld_c");  nstall += !last_pc;
      chk("ld_stall_bub", last_bub, 1);
      step("ld_c_held");                                        nstall += !last_pc;
      set_id(nop, 0);                           step("ld_ex"); nstall += !last_pc;
      chk("ld_fb_wb", last_fb, 1);
      chk("ld_one_stall", nstall, 1);
      drain();

      // r0 is never forwarded nor a hazard.
      set_id(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), 0); step("r0_p");
      set_id(mk(1, 3, 1, 0, 0, 0, 1, 0, 0), 0); step("r0_c");
      set_id(mk(1, 0, 1, 1, 0, 0, 0, 0, 0), 0); step("r0_ld");
      chk("r0_fa", last_fa, 0);
      set_id(mk(1, 3, 1, 0, 0, 0, 1, 0, 1), 0); step("r0_ldc");
      chk("r0_ld_nostall", last_pc, 1);
      drain();

      // Multi-cycle op to r5, dependent reader waits in ID.
      nbusy = 0; nexb = 0; seen = 0;
      set_id(mk(1, 5, 1, 0, 1, 0, 0, 0, 0), 0); step("mul_p");
      set_id(mk(1, 6, 1, 0, 0, 5, 1, 0, 0), 0);
      for (int i = 0; i < 10; i++) begin
         step("mul_wait");
         nbusy += last_busy; nexb += last_exb;
         if (last_busy) seen = 1;
         else if (seen) begin
            chk("mul_dep_fa", last_fa, 2);
            seen = 2;
            break;
         end
      end
      chk("mul_finished", seen, 2);
      chk("mul_busy_cycles", nbusy, MC);
      chk("mul_exb_cycles", nexb, MC - 1);
      drain();

      // Branch coincident with a load-use hazard.
      set_id(mk(1, 6, 1, 1, 0, 0, 0, 0, 0), 0); step("br_ld");
      set_id(mk(1, 3, 1, 0, 0, 6, 1, 0, 0), 1); step("br_hit");
      chk("br_flush", last_flush, 1);
      chk("br_bub", last_bub, 1);
      chk("br_pc", last_pc, 1);
      set_id(nop, 0); step("br_after");
      chk("br_after_pc", last_pc, 1);
      drain();

      // Reset in the second MUL_BUSY cycle.
      set_id(mk(1, 4, 1, 0, 1, 0, 0, 0, 0), 0); step("rm_p");
      set_id(mk(1, 3, 1, 0, 0, 4, 1, 4, 1), 0);
      step("rm_detect");
      step("rm_busy1");
      rst = 1'b1; step("rm_rst");
      rst = 1'b0; step("rm_after");
      chk("rm_busy", last_busy, 0);
      chk("rm_pc", last_pc, 1);
      chk("rm_fwd", last_fa * 4 + last_fb, 0);

      // Random traffic, small register range to provoke hazards.
      for (int n = 0; n < 600; n++) begin
         ins_t r;
         int k;
         k = $urandom_range(0, 7);
         r = mk($urandom_range(0, 5) != 0, 3'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                k < 2, k == 2, 3'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                3'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
         if (r.mr) r.rw = 1;
         rst = ($urandom_range(0, 63) == 0);
         set_id(r, m_ex.v && ($urandom_range(0, 9) == 0));
         step("rand");
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
